// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges ex/bus redirect and stall requests into one pc
// hold/jump/address triple, generates flush pulses and sequences interrupt entry.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] IRQ_CAUSE    = 32'h8000000B
) (
  input  logic        i_Clk,
  input  logic        i_reset,
  input  logic        i_ex_jump_flag,
  input  logic [31:0] i_ex_jump_addr,
  input  logic [31:0] i_ex_next_pc,
  input  logic        i_ex_hold_flag,
  input  logic        i_bus_hold_flag,
  input  logic        i_irq,
  input  logic        i_irq_enable,
  input  logic [31:0] i_mtvec,
  output logic        o_pc_jump_flag,
  output logic [31:0] o_pc_jump_addr,
  output logic        o_pc_hold_flag,
  output logic        o_flush,
  output logic        o_csr_we,
  output logic [11:0] o_csr_waddr,
  output logic [31:0] o_csr_wdata,
  output logic        o_irq_ack
);

  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [2:0]  FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PEND_JUMP  = 3'd1,
    S_IRQ_WAIT   = 3'd2,
    S_IRQ_MEPC   = 3'd3,
    S_IRQ_MCAUSE = 3'd4,
    S_IRQ_JUMP   = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pend_addr;
  logic [31:0] w_pend_addr_nxt;
  logic [31:0] r_mepc;
  logic [31:0] w_mepc_nxt;
  logic [2:0]  r_flush_cnt;
  logic [2:0]  w_flush_cnt_nxt;
  logic        w_jump;
  logic [31:0] w_jump_addr;
  logic        w_hold;
  logic        w_csr_we;
  logic [11:0] w_csr_waddr;
  logic [31:0] w_csr_wdata;
  logic        w_ack;

  // Next-state and output decode
  always_comb begin
    w_next_state    = r_state;
    w_pend_addr_nxt = r_pend_addr;
    w_mepc_nxt      = r_mepc;
    w_jump          = 1'b0;
    w_jump_addr     = 32'h0000_0000;
    w_hold          = 1'b0;
    w_csr_we        = 1'b0;
    w_csr_waddr     = 12'h000;
    w_csr_wdata     = 32'h0000_0000;
    w_ack           = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_jump_addr = i_ex_jump_addr;
        if (i_ex_jump_flag && i_bus_hold_flag) begin
          w_hold          = 1'b1;
          w_pend_addr_nxt = i_ex_jump_addr;
          w_next_state    = S_PEND_JUMP;
        end else begin
          // a redirect wins over an ex stall so jump and hold never coexist
          w_jump = i_ex_jump_flag;
          w_hold = (i_ex_hold_flag | i_bus_hold_flag) & ~i_ex_jump_flag;
          if (i_irq && i_irq_enable) begin
            w_next_state = S_IRQ_WAIT;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      S_PEND_JUMP: begin
        if (i_bus_hold_flag) begin
          w_hold      = 1'b1;
          w_jump_addr = r_pend_addr;
          if (i_ex_jump_flag) begin
            w_pend_addr_nxt = i_ex_jump_addr;
          end else begin
            w_pend_addr_nxt = r_pend_addr;
          end
        end else begin
          w_jump       = 1'b1;
          w_jump_addr  = i_ex_jump_flag ? i_ex_jump_addr : r_pend_addr;
          w_next_state = S_IDLE;
        end
      end
      S_IRQ_WAIT: begin
        w_hold = 1'b1;
        if (i_ex_hold_flag || i_bus_hold_flag) begin
          w_next_state = S_IRQ_WAIT;
        end else begin
          w_mepc_nxt   = i_ex_jump_flag ? i_ex_jump_addr : i_ex_next_pc;
          w_next_state = S_IRQ_MEPC;
        end
      end
      S_IRQ_MEPC: begin
        w_hold       = 1'b1;
        w_csr_we     = 1'b1;
        w_csr_waddr  = CSR_MEPC;
        w_csr_wdata  = r_mepc;
        w_next_state = S_IRQ_MCAUSE;
      end
      S_IRQ_MCAUSE: begin
        w_hold       = 1'b1;
        w_csr_we     = 1'b1;
        w_csr_waddr  = CSR_MCAUSE;
        w_csr_wdata  = IRQ_CAUSE;
        w_next_state = S_IRQ_JUMP;
      end
      S_IRQ_JUMP: begin
        w_jump       = 1'b1;
        w_jump_addr  = i_mtvec;
        w_ack        = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase

    if (w_jump) begin
      w_flush_cnt_nxt = FLUSH_LOAD;
    end else if (w_hold || (r_flush_cnt == 3'd0)) begin
      w_flush_cnt_nxt = r_flush_cnt;
    end else begin
      w_flush_cnt_nxt = r_flush_cnt - 3'd1;
    end
  end

  // State, pending target, captured mepc and flush counter
  always_ff @(posedge i_Clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_pend_addr <= 32'h0000_0000;
      r_mepc      <= 32'h0000_0000;
      r_flush_cnt <= 3'd0;
    end else begin
      r_state     <= w_next_state;
      r_pend_addr <= w_pend_addr_nxt;
      r_mepc      <= w_mepc_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  assign o_pc_jump_flag = w_jump & ~i_reset;
  assign o_pc_jump_addr = i_reset ? 32'h0000_0000 : w_jump_addr;
  assign o_pc_hold_flag = w_hold & ~i_reset;
  assign o_flush        = (w_jump | (r_flush_cnt != 3'd0)) & ~i_reset;
  assign o_csr_we       = w_csr_we & ~i_reset;
  assign o_csr_waddr    = i_reset ? 12'h000 : w_csr_waddr;
  assign o_csr_wdata    = i_reset ? 32'h0000_0000 : w_csr_wdata;
  assign o_irq_ack      = w_ack & ~i_reset;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: single-cycle vector table, directed
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_pipe_ctrl;

  localparam int FLUSH_CYCLES = 2;
  localparam logic [31:0] IRQ_CAUSE = 32'h8000000B;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jf = 1'b0;
  logic [31:0] ja = 32'h0;
  logic [31:0] np = 32'h0;
  logic        exh = 1'b0;
  logic        bh = 1'b0;
  logic        irq = 1'b0;
  logic        ien = 1'b0;
  logic [31:0] mtvec = 32'h0;
  logic        pj;
  logic [31:0] pa;
  logic        ph;
  logic        fl;
  logic        we;
  logic [11:0] waddr;
  logic [31:0] wdata;
  logic        ack;

  int n_cmp = 0;
  int n_err = 0;

  pipe_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .IRQ_CAUSE(IRQ_CAUSE)) dut (
    .i_Clk(clk), .i_reset(rst),
    .i_ex_jump_flag(jf), .i_ex_jump_addr(ja), .i_ex_next_pc(np),
    .i_ex_hold_flag(exh), .i_bus_hold_flag(bh),
    .i_irq(irq), .i_irq_enable(ien), .i_mtvec(mtvec),
    .o_pc_jump_flag(pj), .o_pc_jump_addr(pa), .o_pc_hold_flag(ph),
    .o_flush(fl), .o_csr_we(we), .o_csr_waddr(waddr), .o_csr_wdata(wdata),
    .o_irq_ack(ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic a_jf, input logic [31:0] a_ja, input logic [31:0] a_np,
                       input logic a_exh, input logic a_bh, input logic a_irq,
                       input logic a_ien, input logic [31:0] a_mtvec);
    @(negedge clk);
    jf = a_jf; ja = a_ja; np = a_np; exh = a_exh; bh = a_bh;
    irq = a_irq; ien = a_ien; mtvec = a_mtvec;
    #1;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    jf = 1'b0; ja = 32'h0; np = 32'h0; exh = 1'b0; bh = 1'b0;
    irq = 1'b0; ien = 1'b0; mtvec = 32'h0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic jf; logic [31:0] ja; logic exh; logic bh; logic irq; logic ien;
    logic pj; logic [31:0] pa; logic ph; logic fl;
    logic pj2; logic ph2; logic fl2;
  } vec_t;

  vec_t tbl[8];

  // reference model state
  bit          m_pending;
  logic [31:0] m_pend_addr;
  int          m_irq_step;   // 0 none, 1 quiesce, 2 mepc write, 3 mcause write, 4 vector
  logic [31:0] m_mepc;
  int          m_flush_left;

  task automatic model_reset();
    m_pending = 0; m_pend_addr = 32'h0; m_irq_step = 0; m_mepc = 32'h0; m_flush_left = 0;
  endtask

  task automatic model_step();
    logic e_pj, e_ph, e_we, e_ack;
    logic [31:0] e_pa, e_wdata;
    logic [11:0] e_waddr;
    bit          n_pending;
    logic [31:0] n_pend_addr;
    int          n_step;
    e_pj = 0; e_ph = 0; e_we = 0; e_ack = 0; e_pa = 32'h0; e_wdata = 32'h0; e_waddr = 12'h0;
    n_pending = m_pending; n_pend_addr = m_pend_addr; n_step = m_irq_step;
    if (m_irq_step == 1) begin
      e_ph = 1;
      if (!exh && !bh) begin
        m_mepc = jf ? ja : np;
        n_step = 2;
      end
    end else if (m_irq_step == 2 || m_irq_step == 3) begin
      e_ph = 1; e_we = 1;
      e_waddr = (m_irq_step == 2) ? 12'h341 : 12'h342;
      e_wdata = (m_irq_step == 2) ? m_mepc : IRQ_CAUSE;
      n_step = m_irq_step + 1;
    end else if (m_irq_step == 4) begin
      e_pj = 1; e_pa = mtvec; e_ack = 1; n_step = 0;
    end else if (m_pending) begin
      if (bh) begin
        e_ph = 1;
        if (jf) n_pend_addr = ja;
      end else begin
        e_pj = 1; e_pa = jf ? ja : m_pend_addr; n_pending = 0;
      end
    end else if (jf && bh) begin
      e_ph = 1; n_pending = 1; n_pend_addr = ja;
    end else begin
      e_pj = jf; e_pa = ja;
      e_ph = (exh || bh) && !jf;
      if (irq && ien) n_step = 1;
    end

    chk("rnd_jump", pj, e_pj);
    if (e_pj) chk("rnd_addr", pa, e_pa);
    chk("rnd_hold", ph, e_ph);
    chk("rnd_flush", fl, e_pj || (m_flush_left > 0));
    chk("rnd_we", we, e_we);
    chk("rnd_waddr", waddr, e_waddr);
    chk("rnd_wdata", wdata, e_wdata);
    chk("rnd_ack", ack, e_ack);
    chk("rnd_excl", pj & ph, 1'b0);

    if (e_pj) m_flush_left = FLUSH_CYCLES - 1;
    else if (!e_ph && m_flush_left > 0) m_flush_left--;
    m_pending = n_pending; m_pend_addr = n_pend_addr; m_irq_step = n_step;
  endtask

  initial begin
    //          jf  ja            exh bh  irq ien  pj  pa            ph  fl   pj2 ph2 fl2
    tbl[0] = '{1'b0, 32'h0,       1'b0,1'b0,1'b0,1'b0, 1'b0,32'h0,       1'b0,1'b0, 1'b0,1'b0,1'b0};
    tbl[1] = '{1'b1, 32'h100,     1'b0,1'b0,1'b0,1'b0, 1'b1,32'h100,     1'b0,1'b1, 1'b0,1'b0,1'b1};
    tbl[2] = '{1'b1, 32'h200,     1'b0,1'b1,1'b0,1'b0, 1'b0,32'h200,     1'b1,1'b0, 1'b1,1'b0,1'b1};
    tbl[3] = '{1'b0, 32'h0,       1'b1,1'b0,1'b0,1'b0, 1'b0,32'h0,       1'b1,1'b0, 1'b0,1'b0,1'b0};
    tbl[4] = '{1'b0, 32'h0,       1'b0,1'b1,1'b0,1'b0, 1'b0,32'h0,       1'b1,1'b0, 1'b0,1'b0,1'b0};
    tbl[5] = '{1'b1, 32'h600,     1'b1,1'b0,1'b0,1'b0, 1'b1,32'h600,     1'b0,1'b1, 1'b0,1'b0,1'b1};
    tbl[6] = '{1'b0, 32'h0,       1'b0,1'b0,1'b1,1'b1, 1'b0,32'h0,       1'b0,1'b0, 1'b0,1'b1,1'b0};
    tbl[7] = '{1'b1, 32'hABC,     1'b0,1'b0,1'b1,1'b0, 1'b1,32'hABC,     1'b0,1'b1, 1'b0,1'b0,1'b1};

    // reset state
    rst = 1'b1;
    #2;
    chk("reset_jump", pj, 1'b0);
    chk("reset_hold", ph, 1'b0);
    chk("reset_flush", fl, 1'b0);
    chk("reset_we", we, 1'b0);
    chk("reset_ack", ack, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_reset();
      drive(tbl[i].jf, tbl[i].ja, 32'h0, tbl[i].exh, tbl[i].bh, tbl[i].irq, tbl[i].ien, 32'h0);
      chk($sformatf("tbl%0d_jump", i), pj, tbl[i].pj);
      chk($sformatf("tbl%0d_addr", i), pa, tbl[i].pa);
      chk($sformatf("tbl%0d_hold", i), ph, tbl[i].ph);
      chk($sformatf("tbl%0d_flush", i), fl, tbl[i].fl);
      chk($sformatf("tbl%0d_we", i), we, 1'b0);
      idle_cycle();
      chk($sformatf("tbl%0d_jump2", i), pj, tbl[i].pj2);
      chk($sformatf("tbl%0d_hold2", i), ph, tbl[i].ph2);
      chk($sformatf("tbl%0d_flush2", i), fl, tbl[i].fl2);
    end

    // jump during a 3-cycle bus stall
    do_reset();
    drive(1'b1, 32'h200, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("bs_hold0", ph, 1'b1); chk("bs_jump0", pj, 1'b0);
    for (int c = 1; c < 3; c++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("bs_hold", ph, 1'b1); chk("bs_jump", pj, 1'b0);
    end
    idle_cycle();
    chk("bs_rel_jump", pj, 1'b1); chk("bs_rel_addr", pa, 32'h200);
    chk("bs_rel_hold", ph, 1'b0); chk("bs_rel_flush", fl, 1'b1);
    idle_cycle();
    chk("bs_flush1", fl, 1'b1); chk("bs_jump1", pj, 1'b0);
    idle_cycle();
    chk("bs_flush2", fl, 1'b0);

    // interrupt entry without stalls
    do_reset();
    drive(1'b0, 32'h0, 32'h40, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80);
    chk("irq_acc_hold", ph, 1'b0);
    drive(1'b0, 32'h0, 32'h40, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80);
    chk("irq_wait_hold", ph, 1'b1); chk("irq_wait_we", we, 1'b0);
    drive(1'b0, 32'h0, 32'h44, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80);
    chk("irq_mepc_we", we, 1'b1); chk("irq_mepc_addr", waddr, 12'h341);
    chk("irq_mepc_data", wdata, 32'h40); chk("irq_mepc_hold", ph, 1'b1);
    drive(1'b0, 32'h0, 32'h44, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80);
    chk("irq_mcause_addr", waddr, 12'h342); chk("irq_mcause_data", wdata, IRQ_CAUSE);
    drive(1'b0, 32'h0, 32'h44, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80);
    chk("irq_vec_jump", pj, 1'b1); chk("irq_vec_addr", pa, 32'h80);
    chk("irq_vec_ack", ack, 1'b1); chk("irq_vec_hold", ph, 1'b0);
    chk("irq_vec_we", we, 1'b0); chk("irq_vec_flush", fl, 1'b1);
    idle_cycle();
    chk("irq_post_ack", ack, 1'b0); chk("irq_post_flush", fl, 1'b1);

    // interrupt while ex is busy; release-cycle jump becomes mepc
    do_reset();
    drive(1'b0, 32'h0, 32'h40, 1'b1, 1'b0, 1'b1, 1'b1, 32'h80);
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 32'h0, 32'h40, 1'b1, 1'b0, 1'b1, 1'b1, 32'h80);
      chk("irqh_hold", ph, 1'b1); chk("irqh_we", we, 1'b0); chk("irqh_jump", pj, 1'b0);
    end
    drive(1'b1, 32'h300, 32'h40, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80);
    chk("irqh_rel_jump", pj, 1'b0); chk("irqh_rel_hold", ph, 1'b1);
    idle_cycle();
    chk("irqh_mepc_we", we, 1'b1); chk("irqh_mepc_data", wdata, 32'h300);

    // interrupt masked
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(c == 2, 32'h500, 32'h40, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80);
      chk("mask_we", we, 1'b0); chk("mask_hold", ph, 1'b0); chk("mask_jump", pj, c == 2);
    end

    // reset while writing mepc
    do_reset();
    drive(1'b0, 32'h0, 32'h40, 1'b0, 1'b0, 1'b1, 1'b1, 32'h80);
    drive(1'b0, 32'h0, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80);
    drive(1'b0, 32'h0, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80);
    chk("rm_pre_we", we, 1'b1);
    rst = 1'b1;
    #1;
    chk("rm_we", we, 1'b0); chk("rm_hold", ph, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      idle_cycle();
      chk("rm_ack", ack, 1'b0); chk("rm_we_after", we, 1'b0);
      chk("rm_hold_after", ph, 1'b0); chk("rm_jump_after", pj, 1'b0);
    end
    drive(1'b1, 32'h700, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80);
    chk("rm_idle_jump", pj, 1'b1); chk("rm_idle_addr", pa, 32'h700);

    // randomized run against the model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(3) == 0, $urandom, $urandom,
            $urandom_range(3) == 0, $urandom_range(2) == 0,
            $urandom_range(3) == 0, $urandom_range(1) == 0, $urandom);
      model_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
